// File: rtl/seq_divider.sv
// Multi-cycle signed non-restoring divider: one quotient bit per clock, result
// packed as {remainder, quotient} to feed the HI/LO register pair directly.
module seq_divider #(
    parameter int REG_SIZE = 32
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic [REG_SIZE-1:0]     dividend,
    input  logic [REG_SIZE-1:0]     divisor,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero,
    output logic [2*REG_SIZE-1:0]   c_data_out
);

    // Partial remainder spans (-2|D|, 2|D|) after the shift, with |D| up to 2^(REG_SIZE-1).
    localparam int PW = REG_SIZE + 2;
    localparam int CW = $clog2(REG_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [PW-1:0]          p_r, p_s;
    logic [REG_SIZE-1:0]    q_r, q_s;
    logic [REG_SIZE-1:0]    d_r, d_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic                   neg_q_r, neg_q_s;
    logic                   neg_rem_r, neg_rem_s;
    logic                   zero_div_r, zero_div_s;

    logic                   busy_s, done_s, div_by_zero_s;
    logic [2*REG_SIZE-1:0]  data_s;

    logic [PW-1:0]          shifted_s, stepped_s, rem_full_s;
    logic [REG_SIZE-1:0]    rem_s, quo_s;

    function automatic logic [REG_SIZE-1:0] magnitude(input logic [REG_SIZE-1:0] value);
        if (value[REG_SIZE-1]) begin
            return (~value) + {{(REG_SIZE-1){1'b0}}, 1'b1};
        end else begin
            return value;
        end
    endfunction

    // Next-state, datapath step and registered-output values.
    always_comb begin
        state_s       = state_r;
        p_s           = p_r;
        q_s           = q_r;
        d_s           = d_r;
        cnt_s         = cnt_r;
        neg_q_s       = neg_q_r;
        neg_rem_s     = neg_rem_r;
        zero_div_s    = zero_div_r;
        busy_s        = busy;
        done_s        = 1'b0;
        div_by_zero_s = div_by_zero;
        data_s        = c_data_out;
        shifted_s     = '0;
        stepped_s     = '0;
        rem_full_s    = '0;
        rem_s         = '0;
        quo_s         = '0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    neg_q_s       = dividend[REG_SIZE-1] ^ divisor[REG_SIZE-1];
                    neg_rem_s     = dividend[REG_SIZE-1];
                    d_s           = magnitude(divisor);
                    p_s           = '0;
                    cnt_s         = '0;
                    busy_s        = 1'b1;
                    div_by_zero_s = 1'b0;
                    if (divisor == '0) begin
                        // Raw dividend is parked in the quotient register for the result.
                        q_s        = dividend;
                        zero_div_s = 1'b1;
                        state_s    = FIX;
                    end else begin
                        q_s        = magnitude(dividend);
                        zero_div_s = 1'b0;
                        state_s    = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                shifted_s = {p_r[PW-2:0], q_r[REG_SIZE-1]};
                if (p_r[PW-1]) begin
                    stepped_s = shifted_s + {2'b00, d_r};
                end else begin
                    stepped_s = shifted_s - {2'b00, d_r};
                end
                p_s   = stepped_s;
                q_s   = {q_r[REG_SIZE-2:0], ~stepped_s[PW-1]};
                cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == CW'(REG_SIZE - 1)) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                if (zero_div_r) begin
                    data_s        = {q_r, {REG_SIZE{1'b1}}};
                    div_by_zero_s = 1'b1;
                end else begin
                    if (p_r[PW-1]) begin
                        rem_full_s = p_r + {2'b00, d_r};
                    end else begin
                        rem_full_s = p_r;
                    end
                    rem_s  = neg_rem_r ? (~rem_full_s[REG_SIZE-1:0] + {{(REG_SIZE-1){1'b0}}, 1'b1})
                                       : rem_full_s[REG_SIZE-1:0];
                    quo_s  = neg_q_r ? (~q_r + {{(REG_SIZE-1){1'b0}}, 1'b1}) : q_r;
                    data_s = {rem_s, quo_s};
                end
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r     <= IDLE;
            p_r         <= '0;
            q_r         <= '0;
            d_r         <= '0;
            cnt_r       <= '0;
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            zero_div_r  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            c_data_out  <= '0;
        end else begin
            state_r     <= state_s;
            p_r         <= p_s;
            q_r         <= q_s;
            d_r         <= d_s;
            cnt_r       <= cnt_s;
            neg_q_r     <= neg_q_s;
            neg_rem_r   <= neg_rem_s;
            zero_div_r  <= zero_div_s;
            busy        <= busy_s;
            done        <= done_s;
            div_by_zero <= div_by_zero_s;
            c_data_out  <= data_s;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized
// operands against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic             clock = 1'b0;
    logic             clear;
    logic             start;
    logic [W-1:0]     dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [2*W-1:0]   c_data_out;

    int check_count = 0;
    int fail_count  = 0;

    seq_divider #(.REG_SIZE(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .c_data_out  (c_data_out)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division done in 64-bit arithmetic.
    function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) begin
            return {a, 32'hFFFF_FFFF};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp, input string tag);
        int lat;
        int busy_bad;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check_value({tag, " busy@E0"}, {63'd0, busy}, 64'd1);
        check_value({tag, " dz@E0"}, {63'd0, div_by_zero}, 64'd0);
        lat      = 0;
        busy_bad = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (!done && !busy) busy_bad++;
        end
        check_value({tag, " latency"}, 64'(lat), (b == '0) ? 64'd1 : 64'(W + 1));
        check_value({tag, " data"}, c_data_out, exp);
        check_value({tag, " dz"}, {63'd0, div_by_zero}, {63'd0, (b == '0)});
        check_value({tag, " busy@done"}, {63'd0, busy}, 64'd0);
        check_value({tag, " busy gaps"}, 64'(busy_bad), 64'd0);
        tick();
        check_value({tag, " done width"}, {63'd0, done}, 64'd0);
        check_value({tag, " data hold"}, c_data_out, exp);
        check_value({tag, " dz hold"}, {63'd0, div_by_zero}, {63'd0, (b == '0)});
    endtask

    initial begin
        int lat;
        int seen;
        int mode;
        logic [W-1:0] a;
        logic [W-1:0] b;

        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check_value("reset busy", {63'd0, busy}, 64'd0);
        check_value("reset done", {63'd0, done}, 64'd0);
        check_value("reset dz", {63'd0, div_by_zero}, 64'd0);
        check_value("reset data", c_data_out, 64'd0);
        clear = 1'b0;
        tick();

        do_op(32'd100, 32'd7, 64'h00000002_0000000E, "100/7");
        do_op(32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "-7/2");
        do_op(32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, "7/-2");
        do_op(32'd5, 32'd0, 64'h00000005_FFFFFFFF, "5/0");
        do_op(32'd9, 32'd3, 64'h00000000_00000003, "9/3");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "min/-1");

        // Clear in the middle of a division.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_value("clear busy", {63'd0, busy}, 64'd0);
        check_value("clear done", {63'd0, done}, 64'd0);
        check_value("clear data", c_data_out, 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen++;
        end
        check_value("clear no done", 64'(seen), 64'd0);
        do_op(32'd100, 32'd7, 64'h00000002_0000000E, "post-clear");

        // Start while busy is ignored; start held on the done cycle launches.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 5;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check_value("busy-start latency", 64'(lat), 64'(W + 1));
        check_value("busy-start data", c_data_out, 64'h00000002_0000000E);
        dividend = 32'hFFFF_FF9C;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check_value("b2b done fall", {63'd0, done}, 64'd0);
        check_value("b2b busy", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check_value("b2b latency", 64'(lat), 64'(W + 1));
        check_value("b2b data", c_data_out, ref_div(32'hFFFF_FF9C, 32'd7));
        tick();

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            case (mode)
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 20)) - 32'd10;
                2: b = {16'd0, 16'($urandom)};
                default: begin
                    case ($urandom_range(0, 3))
                        0: b = 32'd0;
                        1: b = 32'd1;
                        2: b = 32'hFFFF_FFFF;
                        default: b = 32'h8000_0000;
                    endcase
                end
            endcase
            do_op(a, b, ref_div(a, b), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
